// File: rtl/key_event_pkg.sv
// Shared definitions for the key event decoder: FSM state encoding and the
// bit positions used when the six event pulses are packed into one vector.
package key_event_pkg;

  // 3-bit state codes
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRESS1 = 3'd1;
  localparam logic [2:0] ST_WAIT2  = 3'd2;
  localparam logic [2:0] ST_PRESS2 = 3'd3;
  localparam logic [2:0] ST_LONG   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    PRESS1 = ST_PRESS1,
    WAIT2  = ST_WAIT2,
    PRESS2 = ST_PRESS2,
    LONG   = ST_LONG
  } key_state_t;

  // Event bit indices for a packed {repeat, long, double, short, release, press} vector
  localparam int EV_PRESS   = 0;
  localparam int EV_RELEASE = 1;
  localparam int EV_SHORT   = 2;
  localparam int EV_DOUBLE  = 3;
  localparam int EV_LONG    = 4;
  localparam int EV_REPEAT  = 5;
  localparam int EV_NUM     = 6;

endpackage

// File: rtl/key_event_decoder.sv
// Turns the debounced active-low key level into one-clock event pulses:
// press, release, short click, double click, long press and auto-repeat.
// One shared cycle counter times whichever threshold the current state uses.
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int          CNT_W      = 32,
  parameter int unsigned LONG_CYC   = 100000000,
  parameter int unsigned DCLK_CYC   = 30000000,
  parameter int unsigned REPEAT_CYC = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_held,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_click,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse
);

  // Terminal counts: a threshold of N cycles is reached when cnt == N-1
  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DCLK_TC   = CNT_W'(DCLK_CYC - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYC - 1);

  logic             key_s;
  logic             pressed;
  key_state_t       state;
  logic [CNT_W-1:0] cnt;

  // Sample register; resets to released so an X on key_n at power-up cannot look like a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_s <= 1'b1;
    end else begin
      key_s <= key_n;
    end
  end

  assign pressed  = ~key_s;
  assign key_held = ~key_s;

  // Gesture FSM with timer and registered one-cycle event outputs; key edges take priority over terminal counts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_click   <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_click   <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (pressed) begin
            state       <= PRESS1;
            press_pulse <= 1'b1;
          end
        end

        PRESS1: begin
          if (!pressed) begin
            state         <= WAIT2;
            cnt           <= '0;
            release_pulse <= 1'b1;
          end else if (cnt == LONG_TC) begin
            state      <= LONG;
            cnt        <= '0;
            long_press <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        WAIT2: begin
          if (pressed) begin
            state       <= PRESS2;
            cnt         <= '0;
            press_pulse <= 1'b1;
          end else if (cnt == DCLK_TC) begin
            state       <= IDLE;
            cnt         <= '0;
            short_click <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        PRESS2: begin
          if (!pressed) begin
            state         <= IDLE;
            cnt           <= '0;
            release_pulse <= 1'b1;
            double_click  <= 1'b1;
          end else if (cnt == LONG_TC) begin
            state      <= LONG;
            cnt        <= '0;
            long_press <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        LONG: begin
          if (!pressed) begin
            state         <= IDLE;
            cnt           <= '0;
            release_pulse <= 1'b1;
          end else if (cnt == REPEAT_TC) begin
            cnt          <= '0;
            repeat_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with short thresholds. Stimulus pushes
// the expected event vector for future cycles into a queue; a negedge monitor
// compares the packed outputs every cycle against whatever is due (zero if nothing).
module tb_key_event_decoder;
  import key_event_pkg::*;

  localparam int LONG_T   = 20;
  localparam int DCLK_T   = 10;
  localparam int REPEAT_T = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key_n;
  logic key_held, press_pulse, release_pulse, short_click;
  logic double_click, long_press, repeat_pulse;

  typedef struct {
    int         at;
    logic [5:0] ev;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         n_asserts = 0;
  int         n_fail = 0;
  logic [5:0] obs;

  key_event_decoder #(
    .CNT_W     (32),
    .LONG_CYC  (LONG_T),
    .DCLK_CYC  (DCLK_T),
    .REPEAT_CYC(REPEAT_T)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_n        (key_n),
    .key_held     (key_held),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_click  (short_click),
    .double_click (double_click),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    obs             = '0;
    obs[EV_PRESS]   = press_pulse;
    obs[EV_RELEASE] = release_pulse;
    obs[EV_SHORT]   = short_click;
    obs[EV_DOUBLE]  = double_click;
    obs[EV_LONG]    = long_press;
    obs[EV_REPEAT]  = repeat_pulse;
  end

  task automatic chk(input string tag, input logic [5:0] o, input logic [5:0] e);
    n_asserts++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, o, e);
    end
  endtask

  task automatic push_ev(input int at, input int bit_i);
    logic [5:0] v;
    v        = '0;
    v[bit_i] = 1'b1;
    q.push_back('{at, v});
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Per-cycle scoreboard check of the packed event outputs
  always @(negedge clk) begin
    logic [5:0] exp_v;
    exp_v = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].at == cyc) begin
        exp_v = exp_v | q[i].ev;
        q.delete(i);
      end
    end
    chk("events", obs, exp_v);
  end

  initial begin
    int p, r, e, t;
    key_n = 1'bx;
    #1 rst = 1'b1;
    #1;
    chk("reset_events", obs, 6'd0);
    chk("reset_held", {5'd0, key_held}, 6'd0);
    wait_cyc(2);
    chk("reset_x_key_held", {5'd0, key_held}, 6'd0);
    key_n = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(4);

    // Single click: low 5, then high; short_click 10 cycles after WAIT2 entry
    p = cyc + 2;
    key_n = 1'b0;
    push_ev(p, EV_PRESS);
    wait_cyc(5);
    chk("held_during_press", {5'd0, key_held}, 6'd1);
    r = cyc + 2;
    key_n = 1'b1;
    push_ev(r, EV_RELEASE);
    push_ev(r + DCLK_T, EV_SHORT);
    wait_cyc(2);
    chk("held_after_release", {5'd0, key_held}, 6'd0);
    wait_cyc(20);

    // Double click: low 5, high 4, low 5, high
    key_n = 1'b0;
    push_ev(cyc + 2, EV_PRESS);
    wait_cyc(5);
    key_n = 1'b1;
    push_ev(cyc + 2, EV_RELEASE);
    wait_cyc(4);
    key_n = 1'b0;
    push_ev(cyc + 2, EV_PRESS);
    wait_cyc(5);
    key_n = 1'b1;
    push_ev(cyc + 2, EV_RELEASE);
    push_ev(cyc + 2, EV_DOUBLE);
    wait_cyc(20);

    // Long hold for 40 cycles: long_press, repeats every 5, release wins over a coincident repeat
    p = cyc + 2;
    r = p + 40;
    key_n = 1'b0;
    push_ev(p, EV_PRESS);
    push_ev(p + LONG_T, EV_LONG);
    for (t = p + LONG_T + REPEAT_T; t < r; t += REPEAT_T) push_ev(t, EV_REPEAT);
    push_ev(r, EV_RELEASE);
    wait_cyc(40);
    key_n = 1'b1;
    wait_cyc(20);

    // Boundary: release seen on the PRESS1 terminal cycle, then second press on the WAIT2 terminal cycle
    p = cyc + 2;
    key_n = 1'b0;
    push_ev(p, EV_PRESS);
    wait_cyc(LONG_T);
    r = cyc + 2;
    key_n = 1'b1;
    push_ev(r, EV_RELEASE);
    wait_cyc(DCLK_T);
    key_n = 1'b0;
    push_ev(cyc + 2, EV_PRESS);
    wait_cyc(5);
    key_n = 1'b1;
    push_ev(cyc + 2, EV_RELEASE);
    push_ev(cyc + 2, EV_DOUBLE);
    wait_cyc(20);

    // Reset mid-hold, asserted just after the first repeat_pulse rises
    p = cyc + 2;
    key_n = 1'b0;
    push_ev(p, EV_PRESS);
    push_ev(p + LONG_T, EV_LONG);
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (cyc != p + LONG_T + REPEAT_T && t < 200);
    chk("reached_repeat", {5'd0, (cyc == p + LONG_T + REPEAT_T)}, 6'd1);
    chk("repeat_before_rst", {5'd0, repeat_pulse}, 6'd1);
    rst = 1'b1;
    #1;
    chk("rst_clears_events", obs, 6'd0);
    chk("rst_clears_held", {5'd0, key_held}, 6'd0);
    q.delete();
    wait_cyc(3);
    rst = 1'b0;
    e = cyc;
    push_ev(e + 2, EV_PRESS);
    push_ev(e + 2 + LONG_T, EV_LONG);
    push_ev(e + 2 + LONG_T + REPEAT_T, EV_REPEAT);
    wait_cyc(30);
    key_n = 1'b1;
    push_ev(cyc + 2, EV_RELEASE);
    wait_cyc(20);

    chk("queue_drained", {5'd0, (q.size() == 0)}, 6'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Consumes the debounced, active-low key level from the key debounce stage and turns it into one-clock event pulses: press, release, short click, double click, long press and auto-repeat.
- Sits between the debounce stage and the application control logic, which reacts to events instead of raw levels.
- Single clock domain, same clock as the debounce stage.

Parameters:
- CNT_W, 32, width of the internal cycle counter.
- LONG_CYC, 100000000, held cycles before long_press fires (1 s at 100 MHz).
- DCLK_CYC, 30000000, window after first release in which a second press counts as a double click (300 ms).
- REPEAT_CYC, 10000000, repeat_pulse period while in the long-press state (100 ms).
- Constraints: all three cycle counts must be >= 2 and < 2^CNT_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- key_n  in  1  debounced key level; 0 = pressed.
- key_held  out  1  registered pressed level (~key_s).
- press_pulse  out  1  one-cycle pulse on each accepted press edge.
- release_pulse  out  1  one-cycle pulse on each release edge.
- short_click  out  1  single click confirmed once the double-click window expires.
- double_click  out  1  second press released before the long threshold.
- long_press  out  1  hold reached LONG_CYC.
- repeat_pulse  out  1  periodic pulse during a long hold.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state IDLE, cnt 0, key_s 1 (released), all outputs 0.
- Input sampling: key_s <= key_n each cycle. key_n is already debounced and synchronous, so no further filtering is applied. pressed = ~key_s.
- Output timing: all outputs are registered pulses, each high for exactly one cycle. Latency is 2 clk from the key_n edge to the output (sample register plus state/output register).
- cnt rules:
  - Clears to 0 on every state entry.
  - Otherwise increments by 1.
  - Terminal count is X_CYC-1 for the active threshold.
  - Never wraps except in LONG.
- FSM transitions:
  - IDLE: pressed -> PRESS1, press_pulse.
  - PRESS1, released -> WAIT2, release_pulse.
  - PRESS1, cnt==LONG_CYC-1 while still pressed -> LONG, long_press.
  - WAIT2, pressed -> PRESS2, press_pulse.
  - WAIT2, cnt==DCLK_CYC-1 while released -> IDLE, short_click.
  - PRESS2, released -> IDLE, release_pulse and double_click.
  - PRESS2, cnt==LONG_CYC-1 while pressed -> LONG, long_press; no double_click and no short_click for that gesture.
  - LONG, cnt==REPEAT_CYC-1 -> repeat_pulse, cnt wraps to 0, stay in LONG.
  - LONG, released -> IDLE, release_pulse; no other event.
- Simultaneous events:
  - Key edge on the same cycle the terminal count is reached: the key edge wins.
  - Release at PRESS1 terminal -> WAIT2, no long_press.
  - Press at WAIT2 terminal -> PRESS2, no short_click.
- Mutual exclusion: at most one of short_click/double_click/long_press fires per gesture. repeat_pulse never coincides with long_press; the first repeat comes REPEAT_CYC cycles after long_press.
- Reset mid-gesture: the gesture is discarded and no event fires. If the key is still low after rst deasserts, a fresh press_pulse follows 2 clk later (IDLE path).
- Power-up X on key_n: key_s reset to 1 guarantees no spurious press before the first valid sample.

Decomposition:
- Package key_event_pkg holds:
  - the state encoding (IDLE, PRESS1, WAIT2, PRESS2, LONG) as a 3-bit localparam set;
  - event bit indices, for benches that pack the six pulses into a vector.
- Timer and FSM stay inline in one module; no sub-module is warranted at this size.

Test Plan (bench params LONG_CYC=20, DCLK_CYC=10, REPEAT_CYC=5):
- Single click: key_n low 5 cycles then high.
  - press_pulse 2 clk after the fall, release_pulse 2 clk after the rise.
  - short_click exactly 10 cycles after entering WAIT2; no other event.
- Double click: low 5, high 4, low 5, high.
  - Two press_pulse, two release_pulse.
  - double_click coincident with the second release_pulse; no short_click.
- Long hold: low for 40 cycles.
  - long_press 20 cycles after PRESS1 entry.
  - repeat_pulse at +5, +10, +15 after long_press.
  - On release: release_pulse only.
- Boundary release: release timed so the key_s rise lands on the PRESS1 cycle with cnt==19 -> WAIT2 path; long_press never asserted.
- Boundary second press: press timed so key_s falls on the WAIT2 cycle with cnt==9 -> PRESS2; short_click never asserted.
- Reset mid-hold: assert rst asynchronously during LONG while key_n stays low.
  - Outputs clear immediately.
  - After deassert: press_pulse at +2 clk, long_press 20 cycles after that.
